// File: rtl/cmflg_ident.sv
// cmflg_ident: sweeps a 2-input gate through 00..11, captures its truth table and names the gate.
// Optional y non-binary checking: define CMFLG_IDENT_XCHECK_EN.
module cmflg_ident #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt,
  output logic [2:0] s_id,
  output logic       valid,
  output logic       xfault
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DECODE,
    DONE
  } state_t;

  localparam logic [3:0] HOLD = 4'(SETTLE);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] vec;
  logic [1:0] vec_nxt;
  logic       y_bad;
  logic       y_bit;
  logic [2:0] dec_id;
  logic       dec_ok;

  assign vec     = {a, b};
  assign vec_nxt = vec + 2'd1;

`ifdef CMFLG_IDENT_XCHECK_EN
  assign y_bad = (y !== 1'b0) && (y !== 1'b1);
`else
  assign y_bad = 1'b0;
`endif

  // A non-binary sample is stored as 0 so tt stays two-valued
  assign y_bit = y_bad ? 1'b0 : y;

  // Truth table to gate selector; unknown patterns decode to 000/invalid
  always_comb begin
    dec_id = 3'b000;
    dec_ok = 1'b0;
    unique case (1'b1)
      (tt == 4'b1100): begin dec_id = 3'b000; dec_ok = 1'b1; end
      (tt == 4'b0011): begin dec_id = 3'b001; dec_ok = 1'b1; end
      (tt == 4'b1000): begin dec_id = 3'b010; dec_ok = 1'b1; end
      (tt == 4'b0111): begin dec_id = 3'b011; dec_ok = 1'b1; end
      (tt == 4'b1110): begin dec_id = 3'b100; dec_ok = 1'b1; end
      (tt == 4'b0001): begin dec_id = 3'b101; dec_ok = 1'b1; end
      (tt == 4'b0110): begin dec_id = 3'b110; dec_ok = 1'b1; end
      (tt == 4'b1001): begin dec_id = 3'b111; dec_ok = 1'b1; end
      default: begin
        dec_id = 3'b000;
        dec_ok = 1'b0;
      end
    endcase
  end

  // Sweep controller with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      a      <= 1'b0;
      b      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tt     <= 4'b0000;
      s_id   <= 3'b000;
      valid  <= 1'b0;
      xfault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          a    <= 1'b0;
          b    <= 1'b0;
          if (start) begin
            state  <= APPLY;
            cnt    <= 4'd0;
            busy   <= 1'b1;
            tt     <= 4'b0000;
            s_id   <= 3'b000;
            valid  <= 1'b0;
            xfault <= 1'b0;
          end
        end
        APPLY: begin
          if (cnt == HOLD) begin
            cnt     <= 4'd0;
            tt[vec] <= y_bit;
            xfault  <= xfault | y_bad;
            if (vec == 2'b11) begin
              state <= DECODE;
              a     <= 1'b0;
              b     <= 1'b0;
            end else begin
              {a, b} <= vec_nxt;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DECODE: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          valid <= dec_ok & ~xfault;
          s_id  <= xfault ? 3'b000 : dec_id;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmflg_ident.sv
// tb_cmflg_ident: directed checks of cmflg_ident against behavioural gates.
// Two instances: SETTLE=1 (main) and SETTLE=0 (held-start timing).
module tb_cmflg_ident;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] s;
  logic       ytie0;

  logic       a1, b1, y1, busy1, done1, valid1, xf1;
  logic [3:0] tt1;
  logic [2:0] sid1;
  logic       a0, b0, y0, busy0, done0, valid0, xf0;
  logic [3:0] tt0;
  logic [2:0] sid0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] tt_tab [8] = '{4'b1100, 4'b0011, 4'b1000, 4'b0111,
                             4'b1110, 4'b0001, 4'b0110, 4'b1001};

  always #5 clk = ~clk;

  function automatic logic gate(input logic [2:0] sel,
                                input logic ga, input logic gb);
    case (sel)
      3'b000:  return ga;
      3'b001:  return ~ga;
      3'b010:  return ga & gb;
      3'b011:  return ~(ga & gb);
      3'b100:  return ga | gb;
      3'b101:  return ~(ga | gb);
      3'b110:  return ga ^ gb;
      3'b111:  return ~(ga ^ gb);
      default: return 1'bx;
    endcase
  endfunction

  assign y1 = ytie0 ? 1'b0 : gate(s, a1, b1);
  assign y0 = ytie0 ? 1'b0 : gate(s, a0, b0);

  cmflg_ident #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .tt(tt1),
    .s_id(sid1), .valid(valid1), .xfault(xf1)
  );

  cmflg_ident #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .tt(tt0),
    .s_id(sid0), .valid(valid0), .xfault(xf0)
  );

  // Pulse start for one edge, return edge index of dut1 done (-1 if none)
  task automatic sweep(output int de);
    de = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done1 && de < 0) de = e;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    s = 3'b000;
    ytie0 = 1'b0;
    #3;
    n_tests++;
    if ({a1, b1, busy1, done1, valid1, xf1, tt1, sid1} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 0",
               {a1, b1, busy1, done1, valid1, xf1, tt1, sid1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_xor_timing;
    int de = -1;
    int nd = 0;
    s = 3'b110;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        nd++;
        if (de < 0) de = e;
      end
      n_tests++;
      if (busy1 !== (e <= 8)) begin
        n_fail++;
        $display("FAIL xor_busy edge %0d: got %b expected %b",
                 e, busy1, (e <= 8));
      end
    end
    n_tests++;
    if (de != 9 || nd != 1) begin
      n_fail++;
      $display("FAIL xor_done: edge %0d count %0d expected edge 9 count 1",
               de, nd);
    end
    n_tests++;
    if ({tt1, sid1, valid1, xf1} !== {4'b0110, 3'b110, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL xor_result: tt %b sid %b valid %b xf %b expected 0110 110 1 0",
               tt1, sid1, valid1, xf1);
    end
    n_tests++;
    if ({a1, b1, a0, b0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_ab: got %b expected 0000", {a1, b1, a0, b0});
    end
    n_tests++;
    if ({tt0, sid0, valid0} !== {4'b0110, 3'b110, 1'b1}) begin
      n_fail++;
      $display("FAIL xor_settle0: tt %b sid %b valid %b expected 0110 110 1",
               tt0, sid0, valid0);
    end
  endtask

  task automatic test_all_gates;
    int de;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      sweep(de);
      n_tests++;
      if (de != 9 || tt1 !== tt_tab[i] || sid1 !== 3'(i) || valid1 !== 1'b1) begin
        n_fail++;
        $display("FAIL gate_%0d: done %0d tt %b sid %b valid %b expected 9 %b %b 1",
                 i, de, tt1, sid1, valid1, tt_tab[i], 3'(i));
      end
    end
  endtask

  task automatic test_y_zero;
    int de;
    ytie0 = 1'b1;
    sweep(de);
    ytie0 = 1'b0;
    n_tests++;
    if (de != 9 || {tt1, valid1, sid1, xf1} !== 9'd0) begin
      n_fail++;
      $display("FAIL y_zero: done %0d tt %b valid %b sid %b xf %b expected 9 0000 0 000 0",
               de, tt1, valid1, sid1, xf1);
    end
  endtask

  task automatic test_xcheck;
    int de;
    s = 3'bxxx;
    sweep(de);
    n_tests++;
`ifdef CMFLG_IDENT_XCHECK_EN
    if ({xf1, valid1, sid1} !== {1'b1, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL xcheck_on: xf %b valid %b sid %b expected 1 0 000",
               xf1, valid1, sid1);
    end
`else
    if (xf1 !== 1'b0 || xf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL xcheck_off: xf %b/%b expected 0/0", xf1, xf0);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    int de;
    s = 3'b110;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 5; e++) @(posedge clk);
    #1;
    n_tests++;
    if ({a1, busy1, tt1} !== {1'b1, 1'b1, 4'b0010}) begin
      n_fail++;
      $display("FAIL mid_state: a %b busy %b tt %b expected 1 1 0010",
               a1, busy1, tt1);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a1, b1, busy1, done1, valid1, xf1, tt1, sid1} !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b expected 0",
               {a1, b1, busy1, done1, valid1, xf1, tt1, sid1});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) nd++;
    end
    n_tests++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL no_done_after_rst: %0d active cycles expected 0", nd);
    end
    s = 3'b011;
    sweep(de);
    n_tests++;
    if (de != 9 || sid1 !== 3'b011 || valid1 !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_sweep: done %0d sid %b valid %b expected 9 011 1",
               de, sid1, valid1);
    end
  endtask

  task automatic test_back_to_back;
    int nd = 0;
    logic exp;
    s = 3'b100;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      @(posedge clk);
      #1;
      if (e == 19) start = 1'b0;
      if (e >= 1) begin
        exp = (e == 5) || (e == 12) || (e == 19);
        if (done0) nd++;
        n_tests++;
        if (done0 !== exp) begin
          n_fail++;
          $display("FAIL held_start_done edge %0d: got %b expected %b",
                   e, done0, exp);
        end
      end
    end
    n_tests++;
    if (nd != 3 || sid0 !== 3'b100 || valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start_sum: pulses %0d sid %b valid %b expected 3 100 1",
               nd, sid0, valid0);
    end
  endtask

  initial begin
    test_reset();
    test_xor_timing();
    test_all_gates();
    test_y_zero();
    test_xcheck();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
